// File: rtl/stat_pkg.sv
// Shared types and constants for the stat drift engine.
package stat_pkg;

  // Two-state controller: normal operation and the single drift-apply cycle.
  typedef enum logic [0:0] {
    StRun,
    StDrift
  } drift_state_e;

  // Galois (right-shift) tap masks for maximal-length LFSRs.
  // 8-bit:  x^8 + x^6 + x^5 + x^4 + 1
  // 16-bit: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_prng.sv
// Free-running Galois LFSR; exposes its low OUT_W bits as a pseudo-random value.
module lfsr_prng
  import stat_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 3,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS = (WIDTH == 16) ? WIDTH'(LFSR_TAPS_16) : WIDTH'(LFSR_TAPS_8);
  // A zero seed would lock the register at zero forever; substitute 1.
  localparam logic [WIDTH-1:0] SAFE_SEED = (SEED == 8'h00) ? WIDTH'(1) : WIDTH'(SEED);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Next state: shift right, fold the tap mask in when a one falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
  end

  // LFSR register, advances every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SAFE_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/stat_drift_engine.sv
// Bank of saturating stats that drift upward on idle ticks and accept care add/subtract requests.
module stat_drift_engine
  import stat_pkg::*;
#(
  parameter int unsigned NUM_STATS = 6,
  parameter int unsigned STAT_W    = 4,
  parameter int unsigned TICK_DIV  = 1000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned RESET_VAL = 0,
  localparam int unsigned IDX_W    = $clog2(NUM_STATS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        idle,
  input  logic                        care_valid,
  output logic                        care_ready,
  input  logic [IDX_W-1:0]            care_idx,
  input  logic                        care_dir,
  input  logic [STAT_W-1:0]           care_amt,
  output logic [NUM_STATS*STAT_W-1:0] stats,
  output logic [NUM_STATS-1:0]        sat_max,
  output logic                        drift_pulse,
  output logic [IDX_W-1:0]            drift_idx
);

  localparam int unsigned       CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;
  localparam logic [IDX_W:0]    NUM_L     = (IDX_W + 1)'(NUM_STATS);

  drift_state_e      state_q;
  logic [CNT_W-1:0]  presc_q;
  logic [IDX_W-1:0]  cand_q;
  logic              drift_pulse_q;
  logic [IDX_W-1:0]  drift_idx_q;
  logic [STAT_W-1:0] stat_q [NUM_STATS];
  logic [STAT_W-1:0] stat_d [NUM_STATS];
  logic [IDX_W-1:0]  rand_idx;
  logic              tick;
  logic              care_fire;
  logic              cand_ok;

  lfsr_prng #(
    .WIDTH (8),
    .OUT_W (IDX_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (rand_idx)
  );

  // Saturating add / clamping subtract, evaluated one bit wider than a stat.
  function automatic logic [STAT_W-1:0] care_apply(input logic [STAT_W-1:0] cur,
                                                   input logic [STAT_W-1:0] amt,
                                                   input logic              add);
    logic [STAT_W:0] wide;
    wide = '0;
    if (add) begin
      wide       = {1'b0, cur} + {1'b0, amt};
      care_apply = wide[STAT_W] ? STAT_MAX : wide[STAT_W-1:0];
    end else begin
      wide       = {1'b0, cur} - {1'b0, amt};
      care_apply = wide[STAT_W] ? '0 : wide[STAT_W-1:0];
    end
  endfunction

  // The prescaler only runs in RUN, so a drift tick period is TICK_DIV + 1 cycles.
  assign tick       = enable && (state_q == StRun) && (presc_q == TICK_LAST);
  assign care_ready = (state_q == StRun) && !reset;
  assign care_fire  = care_valid && care_ready;
  assign cand_ok    = ({1'b0, cand_q} < NUM_L);

  // Tick prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (enable && (state_q == StRun)) begin
      presc_q <= tick ? '0 : presc_q + CNT_W'(1);
    end
  end

  // Control FSM with registered drift strobe and index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      cand_q        <= '0;
      drift_pulse_q <= 1'b0;
      drift_idx_q   <= '0;
    end else begin
      case (state_q)
        StRun: begin
          drift_pulse_q <= 1'b0;
          // Ticks while a button is held are simply dropped.
          if (tick && idle) begin
            state_q <= StDrift;
            cand_q  <= rand_idx;
          end
        end
        StDrift: begin
          state_q       <= StRun;
          drift_pulse_q <= cand_ok;
          if (cand_ok) begin
            drift_idx_q <= cand_q;
          end
        end
        default: begin
          state_q       <= StRun;
          drift_pulse_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel next value; care and drift never coincide since care is blocked in DRIFT.
  always_comb begin
    for (int i = 0; i < NUM_STATS; i++) begin
      stat_d[i] = stat_q[i];
      if (care_fire && (care_idx == IDX_W'(i))) begin
        stat_d[i] = care_apply(stat_q[i], care_amt, care_dir);
      end else if ((state_q == StDrift) && (cand_q == IDX_W'(i))) begin
        stat_d[i] = (stat_q[i] == STAT_MAX) ? STAT_MAX : stat_q[i] + STAT_W'(1);
      end
    end
  end

  // Stat registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        stat_q[i] <= STAT_W'(RESET_VAL);
      end
    end else begin
      for (int i = 0; i < NUM_STATS; i++) begin
        stat_q[i] <= stat_d[i];
      end
    end
  end

  // Pack stats and flag saturated channels.
  always_comb begin
    stats   = '0;
    sat_max = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      stats[i*STAT_W +: STAT_W] = stat_q[i];
      sat_max[i]                = (stat_q[i] == STAT_MAX);
    end
  end

  assign drift_pulse = drift_pulse_q;
  assign drift_idx   = drift_idx_q;

endmodule

// File: doc/stat_drift_engine.md
STAT_DRIFT_ENGINE -- requirements
Module: stat_drift_engine

Interface
REQ-001 NUM_STATS, default 6, number of independent stat channels (2..16).
REQ-002 STAT_W, default 4, width of each stat in bits (2..8).
REQ-003 TICK_DIV, default 1000, clk cycles per drift tick (>=2).
REQ-004 LFSR_SEED, default 8'hA5, non-zero LFSR reset value.
REQ-005 RESET_VAL, default 0, reset value of every stat.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  tick prescaler advances only when high.
REQ-009 idle  input  1  high when no user button is pressed; drift is allowed only when high.
REQ-010 care_valid  input  1  care request present.
REQ-011 care_ready  output  1  care request acceptable this cycle.
REQ-012 care_idx  input  IDX_W=$clog2(NUM_STATS)  target channel.
REQ-013 care_dir  input  1  1 = add, 0 = subtract.
REQ-014 care_amt  input  STAT_W  unsigned amount.
REQ-015 stats  output  NUM_STATS*STAT_W  packed stats, channel i at [i*STAT_W +: STAT_W].
REQ-016 sat_max  output  NUM_STATS  bit i high when stat i equals 2^STAT_W-1.
REQ-017 drift_pulse  output  1  one-cycle strobe when a drift increment is applied.
REQ-018 drift_idx  output  IDX_W  channel of the most recent drift.

Function
REQ-019 The prescaler SHALL count 0..TICK_DIV-1 while enable is high, wrap to 0, and raise internal tick for the cycle it equals TICK_DIV-1; it holds when enable is low.
REQ-020 The FSM SHALL have states RUN and DRIFT; RUN->DRIFT on tick with idle high; DRIFT->RUN unconditionally after one cycle.
REQ-021 A tick with idle low SHALL be discarded, with no drift and no pending state.
REQ-022 On the tick cycle the candidate index SHALL be latched from LFSR[IDX_W-1:0]; an index >= NUM_STATS SHALL yield no drift for that tick.
REQ-023 In DRIFT a valid index SHALL increment its stat by 1, saturating at 2^STAT_W-1.
REQ-024 drift_pulse SHALL assert with the registered stat update, including when the stat is already saturated; drift_idx SHALL update on the same edge.
REQ-025 care_ready SHALL be high in RUN and low in DRIFT and during reset.
REQ-026 A care transfer (care_valid & care_ready) SHALL update stats on the next edge (one-cycle latency); add saturates at 2^STAT_W-1, subtract clamps at 0, and arithmetic uses STAT_W+1 bits.
REQ-027 A care request with care_idx >= NUM_STATS SHALL be accepted and ignored.
REQ-028 A tick and a care transfer in the same RUN cycle SHALL both take effect: care at that edge, drift in the following DRIFT cycle.
REQ-029 The LFSR SHALL advance every clk cycle, independent of enable and idle.
REQ-030 sat_max SHALL be combinational from the registered stats.

Reset
REQ-031 Reset SHALL set stats=RESET_VAL, prescaler=0, FSM=RUN, LFSR=LFSR_SEED, drift_pulse=0, drift_idx=0.
REQ-032 Reset asserted in DRIFT SHALL cancel the pending increment.

Structure
REQ-033 Package stat_pkg SHALL hold the FSM state enum and LFSR tap constants for widths 8 and 16.
REQ-034 The LFSR SHALL be a sub-module lfsr_prng (8-bit Galois, taps x^8+x^6+x^5+x^4+1, seed parameter, no lock-up from non-zero seed).

Verification
REQ-035 Use TICK_DIV=4 with idle=1 and enable=1 after reset: drift_pulse first at cycle 5, then every 5 cycles, each time on the logged drift_idx channel if < 6.
REQ-036 Set idle=0 across a tick: no drift_pulse and stats unchanged; the next tick with idle=1 drifts normally.
REQ-037 Care add of 9 to a stat at 10 with STAT_W=4 -> 15 and sat_max bit set; care subtract of 7 from 3 -> 0.
REQ-038 Present care_valid on the tick cycle: care applied at that edge, care_ready low in the following cycle, and the drift applied one cycle later.
REQ-039 Assert reset for 1 cycle while in DRIFT: no increment, stats=RESET_VAL, care_ready high in the cycle after release.
REQ-040 Issue 20 drifts on a channel preloaded to 15: the stat stays 15 and drift_pulse still asserts each time.
